ext_pipe: RTL and testbench
===========================

# ext_pipe

Pipelined, parametrised extend unit serving both immediate extension (zero, sign, upper-load) and load-data extension (byte, halfword, word, signed or unsigned) behind one valid/ready register stage. It sits between the datapath source (the decoder for immediates, data memory for loads) and the writeback or operand mux. It replaces the purely combinational extender in the pipelined core. It adds load-lane selection, a tag side-band, back-pressure, flush and optional misalignment detection.

## Interface
- DATA_W, 32: output and load-data width; a multiple of 32 and ≥ 2*IMM_W.
- IMM_W, 16: immediate width.
- TAG_W, 5: side-band tag width (destination register index), passed through unchanged.
- OFF_W, $clog2(DATA_W/8): byte-offset width (localparam).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit can accept the input beat this cycle.
- in_mode  in  4  operation code, values from ext_pkg.
- in_imm  in  IMM_W  immediate operand.
- in_data  in  DATA_W  raw memory word for load modes.
- in_off  in  OFF_W  byte address low bits for load modes.
- in_tag  in  TAG_W  side-band tag.
- flush  in  1  discards the registered beat and any beat offered this cycle.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  extended result.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  address error flag; constant 0 unless EXT_MISALIGN_CHK_EN is defined.

## Operation
- Modes:
  - ZERO=0: zero-extend in_imm.
  - SIGN=1: sign-extend in_imm.
  - LUI=2: in_imm placed at bits [2*IMM_W-1:IMM_W]; bits below are 0; bits above are a copy of in_imm[IMM_W-1].
  - LB=3 / LBU=4: byte lane in_off selected from in_data; sign-extended (LB) or zero-extended (LBU).
  - LH=5 / LHU=6: halfword lane in_off[OFF_W-1:1] selected; sign-extended (LH) or zero-extended (LHU).
  - LW=7: 32-bit lane in_off[OFF_W-1:2] selected; sign-extended to DATA_W (identity when DATA_W=32).
  - 8–15 reserved: out_data = 0.
- Lane 0 is bits [7:0] (little-endian).
- in_data and in_off are ignored in modes 0–2. in_imm is ignored in modes 3–7.
- Accept: a beat is accepted when in_valid && in_ready && !flush.
- Stage register: on accept, out_data/out_tag/out_err load the computed values and out_valid is set.
- Drain: when out_valid && out_ready and there is no new accept, out_valid clears.
- Hold: while out_valid && !out_ready, out_data, out_tag and out_err stay stable.
- Flush: flush has priority over every other event. Next edge out_valid = 0. The beat offered in the flush cycle is dropped. The data registers may keep stale contents.
- Reset: out_valid = 0, out_data = 0, out_tag = 0, out_err = 0. An in-flight beat is lost.

## Timing
- Latency 1 cycle: a beat accepted at edge N is visible on out_* after edge N.
- Throughput 1 beat/cycle when out_ready is held high.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no other combinational input-to-output path.
- Simultaneous drain and accept: the new beat replaces the old one and out_valid stays 1.
- No beat is duplicated or skipped under any in_valid/out_ready pattern.

## Configuration
- EXT_MISALIGN_CHK_EN defined:
  - out_err = 1 for LH/LHU with in_off[0]=1, LW with in_off[1:0]≠0, or a reserved mode.
  - Whenever out_err = 1, out_data is forced to 0.
  - out_err travels with its beat through the stage register.
- Not defined: out_err is tied to 0. Misaligned loads return the lane selected by truncated offset bits (low bits ignored); reserved modes still return 0.

## Structure
- Package ext_pkg:
  - mode localparams EXT_ZERO…EXT_LW and EXT_MODE_W=4;
  - lane-size constants BYTE_W=8, HALF_W=16, WORD_W=32.
- Sub-module ext_core: purely combinational mode/lane/extend logic, including the error computation.
- ext_pipe owns only the handshake, the stage register and flush/reset.

## Test plan
- SIGN, in_imm=16'h8000, out_ready=1 -> out_data=32'hFFFF8000 one cycle later. LUI, in_imm=16'h1234 -> 32'h12340000.
- LB, in_data=32'h80FF7F01, in_off=3 -> 32'hFFFFFF80. LBU, same inputs -> 32'h00000080. LHU, in_off=2 -> 32'h000080FF.
- Back-to-back beats with out_ready held low for 3 cycles -> out_data/out_tag stable and in_ready=0 throughout. On release, every beat appears in order exactly once.
- Beat registered, then flush pulsed while in_valid=1 -> out_valid=0 next cycle; the offered beat never appears.
- With EXT_MISALIGN_CHK_EN: LW, in_off=2 -> out_err=1, out_data=0. LH, in_off=2 -> out_err=0. Mode 9 -> out_err=1.
- reset asserted mid-stream, asynchronously between edges -> out_valid=0 and all outputs 0 immediately. The first beat after release has 1-cycle latency.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: mode codes and lane sizes shared by the extend unit.
// Misalignment checking is enabled by defining EXT_MISALIGN_CHK_EN.
package ext_pkg;

    localparam int EXT_MODE_W = 4;

    typedef logic [EXT_MODE_W-1:0] ext_mode_t;

    localparam ext_mode_t EXT_ZERO = 4'd0;
    localparam ext_mode_t EXT_SIGN = 4'd1;
    localparam ext_mode_t EXT_LUI  = 4'd2;
    localparam ext_mode_t EXT_LB   = 4'd3;
    localparam ext_mode_t EXT_LBU  = 4'd4;
    localparam ext_mode_t EXT_LH   = 4'd5;
    localparam ext_mode_t EXT_LHU  = 4'd6;
    localparam ext_mode_t EXT_LW   = 4'd7;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational mode decode, load-lane select and extension.
// Address error output is live only when EXT_MISALIGN_CHK_EN is defined.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    localparam int OFF_W = $clog2(DATA_W/8)
) (
    input  logic [EXT_MODE_W-1:0] mode,
    input  logic [IMM_W-1:0]      imm,
    input  logic [DATA_W-1:0]     data,
    input  logic [OFF_W-1:0]      off,
    output logic [DATA_W-1:0]     result,
    output logic                  err
);

    // Half and word lanes ignore the low offset bits.
    logic [OFF_W-1:0]    hoff;
    logic [OFF_W-1:0]    woff;
    logic [BYTE_W-1:0]   lb;
    logic [HALF_W-1:0]   lh;
    logic [WORD_W-1:0]   lw;
    logic [2*IMM_W-1:0]  upper;
    logic [DATA_W-1:0]   res;

    assign hoff  = off & ~OFF_W'(1);
    assign woff  = off & ~OFF_W'(3);
    assign lb    = BYTE_W'(data >> {off, 3'b000});
    assign lh    = HALF_W'(data >> {hoff, 3'b000});
    assign lw    = WORD_W'(data >> {woff, 3'b000});
    assign upper = {imm, {IMM_W{1'b0}}};

    always_comb begin
        res = '0;
        unique case (mode)
            EXT_ZERO: res = DATA_W'(imm);
            EXT_SIGN: res = DATA_W'($signed(imm));
            EXT_LUI:  res = DATA_W'($signed(upper));
            EXT_LB:   res = DATA_W'($signed(lb));
            EXT_LBU:  res = DATA_W'(lb);
            EXT_LH:   res = DATA_W'($signed(lh));
            EXT_LHU:  res = DATA_W'(lh);
            EXT_LW:   res = DATA_W'($signed(lw));
            default:  res = '0;
        endcase
    end

`ifdef EXT_MISALIGN_CHK_EN
    logic misal;

    always_comb begin
        misal = 1'b0;
        unique case (mode)
            EXT_ZERO, EXT_SIGN, EXT_LUI,
            EXT_LB, EXT_LBU: misal = 1'b0;
            EXT_LH, EXT_LHU: misal = off[0];
            EXT_LW:          misal = |off[1:0];
            default:         misal = 1'b1;
        endcase
    end

    assign err    = misal;
    assign result = misal ? '0 : res;
`else
    assign err    = 1'b0;
    assign result = res;
`endif

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: one valid/ready register stage around ext_core with flush.
// Optional address error checking via EXT_MISALIGN_CHK_EN.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = 5,
    localparam int OFF_W = $clog2(DATA_W/8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXT_MODE_W-1:0] in_mode,
    input  logic [IMM_W-1:0]      in_imm,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [OFF_W-1:0]      in_off,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_err
);

    logic              accept;
    logic [DATA_W-1:0] core_data;
    logic              core_err;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .mode   (in_mode),
        .imm    (in_imm),
        .data   (in_data),
        .off    (in_off),
        .result (core_data),
        .err    (core_err)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= core_data;
            out_tag   <= in_tag;
            out_err   <= core_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe with a behavioural model.
// Checks error behaviour too when EXT_MISALIGN_CHK_EN is defined.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mode;
    logic [15:0] in_imm;
    logic [31:0] in_data;
    logic [1:0]  in_off;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        logic        e;
    } exp_t;

    exp_t q[$];

    logic        prev_hold = 1'b0;
    logic [31:0] hd;
    logic [4:0]  ht;
    logic        he;

    ext_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_imm    (in_imm),
        .in_data   (in_data),
        .in_off    (in_off),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the mode rules.
    function automatic void model(input logic [3:0] m, input logic [15:0] i,
                                  input logic [31:0] d, input logic [1:0] o,
                                  output logic [31:0] r, output logic e);
        longint unsigned v;
        r = 0;
        e = 0;
        case (m)
            0: r = 32'(i);
            1: begin
                r = 32'(i);
                if (i >= 16'd32768) r = r + 32'hFFFF0000;
            end
            2: r = 32'(i) * 32'd65536;
            3, 4: begin
                v = (longint'(d) >> (8 * o)) % 256;
                r = 32'(v);
                if (m == 3 && v >= 128) r = r + 32'hFFFFFF00;
            end
            5, 6: begin
                v = (longint'(d) >> (16 * (o / 2))) % 65536;
                r = 32'(v);
                if (m == 5 && v >= 32768) r = r + 32'hFFFF0000;
                e = (o % 2) != 0;
            end
            7: begin
                r = d;
                e = (o != 0);
            end
            default: begin
                r = 0;
                e = 1;
            end
        endcase
`ifdef EXT_MISALIGN_CHK_EN
        if (e) r = 0;
`else
        e = 0;
`endif
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t x;
        exp_t y;
        logic rdy_exp;
        if (!reset) begin
            q.delete();
            prev_hold = 1'b0;
        end else begin
            rdy_exp = (q.size() == 0) || out_ready;
            compared++;
            if (out_valid !== (q.size() != 0)) begin
                mismatched++;
                $display("FAIL out_valid: got %b want %b", out_valid, q.size() != 0);
            end
            compared++;
            if (in_ready !== rdy_exp) begin
                mismatched++;
                $display("FAIL in_ready: got %b want %b", in_ready, rdy_exp);
            end
            if (prev_hold) begin
                compared++;
                if (out_data !== hd || out_tag !== ht || out_err !== he) begin
                    mismatched++;
                    $display("FAIL hold: got %h/%h/%b want %h/%h/%b",
                             out_data, out_tag, out_err, hd, ht, he);
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                x = q.pop_front();
                compared++;
                if (out_data !== x.d || out_tag !== x.t || out_err !== x.e) begin
                    mismatched++;
                    $display("FAIL beat: got %h/%h/%b want %h/%h/%b",
                             out_data, out_tag, out_err, x.d, x.t, x.e);
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && rdy_exp) begin
                model(in_mode, in_imm, in_data, in_off, y.d, y.e);
                y.t = in_tag;
                q.push_back(y);
            end
            prev_hold = out_valid && !out_ready && !flush;
            hd = out_data;
            ht = out_tag;
            he = out_err;
        end
    end

    task automatic send(input logic [3:0] m, input logic [15:0] i,
                        input logic [31:0] d, input logic [1:0] o,
                        input logic [4:0] t);
        int n = 0;
        logic acc;
        in_mode  = m;
        in_imm   = i;
        in_data  = d;
        in_off   = o;
        in_tag   = t;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: got no accept want accept tag %h", t);
        end
    endtask

    task automatic directed(input string nm, input logic [3:0] m,
                            input logic [15:0] i, input logic [31:0] d,
                            input logic [1:0] o, input logic [31:0] ed,
                            input logic ee);
        send(m, i, d, o, 5'h11);
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (!(out_valid === 1'b1 && out_data === ed && out_err === ee)) begin
            mismatched++;
            $display("FAIL %s: got v=%b %h err=%b want v=1 %h err=%b",
                     nm, out_valid, out_data, out_err, ed, ee);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = '0;
        in_imm    = '0;
        in_data   = '0;
        in_off    = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 ||
            out_tag !== 5'h0 || out_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: got %b %h %h %b want 0 0 0 0",
                     out_valid, out_data, out_tag, out_err);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        directed("sign",  4'd1, 16'h8000, 32'h0, 2'd0, 32'hFFFF8000, 1'b0);
        directed("lui",   4'd2, 16'h1234, 32'h0, 2'd0, 32'h12340000, 1'b0);
        directed("lb",    4'd3, 16'h0, 32'h80FF7F01, 2'd3, 32'hFFFFFF80, 1'b0);
        directed("lbu",   4'd4, 16'h0, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0);
        directed("lhu",   4'd6, 16'h0, 32'h80FF7F01, 2'd2, 32'h000080FF, 1'b0);
        directed("lh",    4'd5, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0);
`ifdef EXT_MISALIGN_CHK_EN
        directed("lw_mis", 4'd7, 16'h0, 32'h80FF7F01, 2'd2, 32'h0, 1'b1);
        directed("rsv9",   4'd9, 16'h5555, 32'h12345678, 2'd0, 32'h0, 1'b1);
`else
        directed("lw_trunc", 4'd7, 16'h0, 32'h80FF7F01, 2'd2, 32'h80FF7F01, 1'b0);
        directed("rsv9",     4'd9, 16'h5555, 32'h12345678, 2'd0, 32'h0, 1'b0);
`endif

        // Back-pressure: one beat parked, next beat held off for 3 cycles.
        out_ready = 1'b0;
        send(4'd0, 16'hAAAA, 32'h0, 2'd0, 5'h01);
        in_mode = 4'd1;
        in_imm  = 16'hBBBB;
        in_tag  = 5'h02;
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_ready: got %b want 0", in_ready);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(4'd1, 16'hBBBB, 32'h0, 2'd0, 5'h02);
        send(4'd4, 16'h0, 32'hCAFEF00D, 2'd1, 5'h03);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Flush drops the parked beat and the beat offered alongside it.
        out_ready = 1'b0;
        send(4'd0, 16'h0777, 32'h0, 2'd0, 5'h04);
        in_imm   = 16'h0888;
        in_tag   = 5'h05;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush: got out_valid %b want 0", out_valid);
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(4'd6, 16'h0, 32'hDEADBEEF, 2'd2, 5'h06);
        in_imm = 16'h0999;
        #2 reset = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 ||
            out_tag !== 5'h0 || out_err !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: got %b %h %h %b want 0 0 0 0",
                     out_valid, out_data, out_tag, out_err);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;
        directed("post_rst", 4'd0, 16'hABCD, 32'h0, 2'd0, 32'h0000ABCD, 1'b0);

        // Randomised traffic.
        repeat (400) begin
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 7);
            flush     = ($urandom_range(19) == 0);
            in_mode   = 4'($urandom_range(15));
            in_imm    = 16'($urandom);
            in_data   = $urandom;
            in_off    = 2'($urandom_range(3));
            in_tag    = 5'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
